// File: rtl/core_ras_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_ras_pkg
//  Purpose  : Shared types, BTB type encodings and operation select for the
//             return address stack.
//  Revision : 1.0  initial release
// ============================================================================
package core_ras_pkg;

  // BTB entry type encodings
  localparam logic [1:0] c_br_type  = 2'b00;
  localparam logic [1:0] c_j_type   = 2'b01;
  localparam logic [1:0] c_jal_type = 2'b10;
  localparam logic [1:0] c_jr_type  = 2'b11;

  localparam logic [31:0] c_rst_addr = 32'h0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } ras_op_e;

  typedef struct packed {
    ras_op_e     op;
    logic [31:0] addr;
  } ras_req_t;

  // Decode redirect outranks the speculative fetch-side op; at most one op per cycle.
  function automatic ras_req_t sel_op(
    input logic        id_pc_src,
    input logic        id_push,
    input logic        id_pop,
    input logic [31:0] id_addr,
    input logic        pc_go,
    input logic        stall,
    input logic        btb_v,
    input logic [1:0]  btb_type,
    input logic [31:0] pc_plus4,
    input logic        empty
  );
    ras_req_t req;
    req.op   = OP_HOLD;
    req.addr = pc_plus4;
    if (id_pc_src) begin
      req.addr = id_addr;
      if (id_push && id_pop) begin
        // Replacing the top of an empty stack degenerates to a push.
        req.op = empty ? OP_PUSH : OP_REPL;
      end else if (id_push) begin
        req.op = OP_PUSH;
      end else if (id_pop) begin
        req.op = OP_POP;
      end
    end else if (pc_go && !stall && btb_v) begin
      if (btb_type == c_jal_type) begin
        req.op = OP_PUSH;
      end else if (btb_type == c_jr_type) begin
        req.op = OP_POP;
      end
    end
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_ras.sv
`default_nettype none
// ============================================================================
//  Module   : core_ras
//  Purpose  : Circular overwrite-oldest return address stack for fetch.
//  Revision : 1.0  initial release
// ============================================================================
module core_ras
  import core_ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_go,
  input  logic          stall,
  input  logic          btb_v,
  input  logic [1:0]    btb_type,
  input  logic [31:0]   pc_plus4,
  input  logic          id_pc_src,
  input  logic          id_ras_push,
  input  logic          id_ras_pop,
  input  logic [31:0]   id_ras_addr,
  output logic [31:0]   ras_target,
  output logic          ras_v,
  output logic [AW:0]   ras_count
);

  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_tp_one  = AW'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_tp;
  logic [AW:0]   r_count;

  ras_req_t      w_req;
  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_tp_inc;
  logic [AW-1:0] w_tp_dec;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_depth);
  assign w_tp_inc = r_tp + c_tp_one;
  assign w_tp_dec = r_tp - c_tp_one;

  assign w_req = sel_op(id_pc_src, id_ras_push, id_ras_pop, id_ras_addr,
                        pc_go, stall, btb_v, btb_type, pc_plus4, w_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= c_rst_addr;
      end
    end else begin
      case (w_req.op)
        OP_PUSH: begin
          // Pointer wraps modulo DEPTH, so a full push lands on the oldest slot.
          r_tp            <= w_tp_inc;
          r_mem[w_tp_inc] <= w_req.addr;
          if (!w_full) begin
            r_count <= r_count + c_cnt_one;
          end
        end
        OP_POP: begin
          if (!w_empty) begin
            r_tp    <= w_tp_dec;
            r_count <= r_count - c_cnt_one;
          end
        end
        OP_REPL: begin
          r_mem[r_tp] <= w_req.addr;
        end
        default: begin
        end
      endcase
    end
  end

  assign ras_v      = !w_empty;
  assign ras_target = w_empty ? c_rst_addr : r_mem[r_tp];
  assign ras_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_core_ras.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_ras
//  Purpose  : Scoreboarded testbench for core_ras against a queue-based stack.
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_ras;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_go;
  logic          stall;
  logic          btb_v;
  logic [1:0]    btb_type;
  logic [31:0]   pc_plus4;
  logic          id_pc_src;
  logic          id_ras_push;
  logic          id_ras_pop;
  logic [31:0]   id_ras_addr;
  logic [31:0]   ras_target;
  logic          ras_v;
  logic [AW:0]   ras_count;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] tgt;
    int          cnt;
    string       tag;
  } exp_t;

  exp_t        r_sb[$];
  logic [31:0] r_stk[$];

  core_ras #(.DEPTH(DEPTH), .AW(AW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_go       (pc_go),
    .stall       (stall),
    .btb_v       (btb_v),
    .btb_type    (btb_type),
    .pc_plus4    (pc_plus4),
    .id_pc_src   (id_pc_src),
    .id_ras_push (id_ras_push),
    .id_ras_pop  (id_ras_pop),
    .id_ras_addr (id_ras_addr),
    .ras_target  (ras_target),
    .ras_v       (ras_v),
    .ras_count   (ras_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; pc_go = 0; stall = 0; btb_v = 0; btb_type = 2'b00; pc_plus4 = 32'h0;
    id_pc_src = 0; id_ras_push = 0; id_ras_pop = 0; id_ras_addr = 32'h0;
  endtask

  task automatic mdl_push(input logic [31:0] a);
    r_stk.push_back(a);
    if (r_stk.size() > DEPTH) void'(r_stk.pop_front());
  endtask

  // Reference model: update stack from the currently driven inputs, queue expectation.
  task automatic mdl_step(input string tag);
    exp_t e;
    if (rst) begin
      r_stk.delete();
    end else if (id_pc_src) begin
      if (id_ras_push && id_ras_pop) begin
        if (r_stk.size() == 0) mdl_push(id_ras_addr);
        else r_stk[r_stk.size()-1] = id_ras_addr;
      end else if (id_ras_push) begin
        mdl_push(id_ras_addr);
      end else if (id_ras_pop) begin
        if (r_stk.size() > 0) void'(r_stk.pop_back());
      end
    end else if (pc_go && !stall && btb_v) begin
      if (btb_type == 2'b10) mdl_push(pc_plus4);
      else if (btb_type == 2'b11 && r_stk.size() > 0) void'(r_stk.pop_back());
    end
    e.tgt = (r_stk.size() > 0) ? r_stk[r_stk.size()-1] : 32'h0;
    e.cnt = r_stk.size();
    e.tag = tag;
    r_sb.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    mdl_step(tag);
    @(posedge clk);
    #1;
    if (r_sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = r_sb.pop_front();
      chk({e.tag, ".tgt"}, ras_target, e.tgt);
      chk({e.tag, ".cnt"}, 32'(ras_count), 32'(e.cnt));
      chk({e.tag, ".v"}, 32'(ras_v), 32'(e.cnt != 0));
    end
    idle();
  endtask

  task automatic fetch(input logic [1:0] t, input logic [31:0] a, input string tag);
    pc_go = 1; stall = 0; btb_v = 1; btb_type = t; pc_plus4 = a;
    cyc(tag);
  endtask

  task automatic idop(input logic p, input logic q, input logic [31:0] a, input string tag);
    id_pc_src = 1; id_ras_push = p; id_ras_pop = q; id_ras_addr = a;
    cyc(tag);
  endtask

  initial begin
    idle();
    rst = 1;
    cyc("rst0");
    rst = 1;
    cyc("rst1");
    chk("rst_tgt", ras_target, 32'h0);
    chk("rst_cnt", 32'(ras_count), 32'd0);

    fetch(2'b11, 32'h0, "underflow");
    chk("uf_tgt", ras_target, 32'h0);

    fetch(2'b10, 32'h00040004, "jal1");
    fetch(2'b10, 32'h00040104, "jal2");
    chk("jal2_tgt", ras_target, 32'h00040104);
    chk("jal2_cnt", 32'(ras_count), 32'd2);
    fetch(2'b11, 32'h0, "jr1");
    chk("jr1_tgt", ras_target, 32'h00040004);
    fetch(2'b11, 32'h0, "jr2");

    for (int k = 0; k < 9; k++) fetch(2'b10, 32'h1000 + 32'(4*k), "wrap_push");
    chk("full_cnt", 32'(ras_count), 32'd8);
    chk("full_tgt", ras_target, 32'h1020);
    for (int k = 0; k < 8; k++) begin
      chk("wrap_top", ras_target, 32'h1020 - 32'(4*k));
      fetch(2'b11, 32'h0, "wrap_pop");
    end
    chk("wrap_cnt", 32'(ras_count), 32'd0);
    chk("wrap_v", 32'(ras_v), 32'd0);
    fetch(2'b11, 32'h0, "wrap_uf");

    fetch(2'b10, 32'h500, "base");
    pc_go = 1; stall = 1; btb_v = 1; btb_type = 2'b10; pc_plus4 = 32'h600;
    cyc("stalled");
    pc_go = 0; stall = 0; btb_v = 1; btb_type = 2'b10; pc_plus4 = 32'h700;
    cyc("no_go");
    chk("hold_tgt", ras_target, 32'h500);
    fetch(2'b00, 32'h800, "br_hit");
    fetch(2'b01, 32'h900, "j_hit");
    id_ras_push = 1; id_ras_addr = 32'h999;
    cyc("id_no_src");

    pc_go = 1; btb_v = 1; btb_type = 2'b10; pc_plus4 = 32'h2004;
    id_pc_src = 1; id_ras_push = 1; id_ras_addr = 32'h3000;
    cyc("id_cancel");
    chk("idc_tgt", ras_target, 32'h3000);
    chk("idc_cnt", 32'(ras_count), 32'd2);

    rst = 1;
    cyc("rst2");
    idop(1, 0, 32'hA0, "a0");
    idop(1, 0, 32'hB0, "b0");
    idop(1, 1, 32'hC0, "repl");
    chk("repl_tgt", ras_target, 32'hC0);
    chk("repl_cnt", 32'(ras_count), 32'd2);
    idop(0, 1, 32'h0, "idpop");
    chk("idpop_tgt", ras_target, 32'hA0);
    idop(0, 1, 32'h0, "idpop2");
    idop(1, 1, 32'hD0, "repl_empty");
    chk("rple_tgt", ras_target, 32'hD0);
    idop(0, 0, 32'hE0, "id_none");

    for (int n = 0; n < 300; n++) begin
      rst         = ($urandom_range(0, 40) == 0);
      pc_go       = 1'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      btb_v       = 1'($urandom);
      btb_type    = 2'($urandom);
      pc_plus4    = $urandom;
      id_pc_src   = ($urandom_range(0, 3) == 0);
      id_ras_push = 1'($urandom);
      id_ras_pop  = 1'($urandom);
      id_ras_addr = $urandom;
      cyc("rand");
    end

    chk("sb_drained", 32'(r_sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
